cp0_exception_ctrl: RTL and testbench

Coprocessor-0 register file plus exception sequencer for the 5-stage MIPS core. It consumes the prioritised `exception_type` produced for the MEM-stage instruction and commits the precise-exception side effects to Status, Cause, EPC and BadVAddr. It then issues a one-cycle pipeline flush and PC redirect. It also owns Count/Compare timer generation, interrupt-pending sampling and MTC0/MFC0 access. It feeds Status/Cause back to the exception prioritiser.

---
 rtl/cp0_exception_ctrl_pkg.sv | 60 ++++++
 rtl/cp0_exception_ctrl_timer.sv | 54 +++++
 rtl/cp0_exception_ctrl.sv | 143 ++++++++++++++
 tb/tb_cp0_exception_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_exception_ctrl_pkg.sv
// Shared CP0 constants: exception type codes, register numbers, field
// positions, MTC0 write masks and the exception-type to ExcCode mapping.
// Imported by cp0_exception_ctrl and cp0_exception_ctrl_timer.
package cp0_exception_ctrl_pkg;

  // exception_type codes produced by the prioritiser (0 = no exception)
  localparam logic [31:0] EXC_NONE    = 32'd0;
  localparam logic [31:0] EXC_INT     = 32'd1;
  localparam logic [31:0] EXC_ADEL    = 32'd2;
  localparam logic [31:0] EXC_ADES    = 32'd3;
  localparam logic [31:0] EXC_SYSCALL = 32'd4;
  localparam logic [31:0] EXC_BREAK   = 32'd5;
  localparam logic [31:0] EXC_RI      = 32'd6;
  localparam logic [31:0] EXC_OVF     = 32'd7;
  localparam logic [31:0] EXC_ERET    = 32'd8;

  // CP0 register numbers
  localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
  localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_REG_EPC      = 5'd14;

  // field positions
  localparam int CP0_STATUS_EXL        = 1;
  localparam int CP0_STATUS_IE         = 0;
  localparam int CP0_CAUSE_BD          = 31;
  localparam int CP0_CAUSE_IPS_MSB     = 15;  // hardware IP[7:2]
  localparam int CP0_CAUSE_IPS_LSB     = 10;
  localparam int CP0_CAUSE_EXCCODE_MSB = 6;
  localparam int CP0_CAUSE_EXCCODE_LSB = 2;

  // MTC0-writable bits
  localparam logic [31:0] CP0_STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CP0_CAUSE_WMASK  = 32'h0000_0300;

  // ExcCode values
  localparam logic [4:0] EXCCODE_INT  = 5'd0;
  localparam logic [4:0] EXCCODE_ADEL = 5'd4;
  localparam logic [4:0] EXCCODE_ADES = 5'd5;
  localparam logic [4:0] EXCCODE_SYS  = 5'd8;
  localparam logic [4:0] EXCCODE_BP   = 5'd9;
  localparam logic [4:0] EXCCODE_RI   = 5'd10;
  localparam logic [4:0] EXCCODE_OV   = 5'd12;

  // Unknown non-zero types are reported as reserved instruction.
  function automatic logic [4:0] exc_code(input logic [31:0] exc_type);
    case (exc_type)
      EXC_INT:     exc_code = EXCCODE_INT;
      EXC_ADEL:    exc_code = EXCCODE_ADEL;
      EXC_ADES:    exc_code = EXCCODE_ADES;
      EXC_SYSCALL: exc_code = EXCCODE_SYS;
      EXC_BREAK:   exc_code = EXCCODE_BP;
      EXC_OVF:     exc_code = EXCCODE_OV;
      default:     exc_code = EXCCODE_RI;
    endcase
  endfunction

endpackage

// File: rtl/cp0_exception_ctrl_timer.sv
// CP0 Count/Compare timer: Count advances every second cycle, timer_pending
// latches on Count==Compare (Compare!=0) and clears on any Compare write.
// Ports: clk/rst, count_we/compare_we + wdata, count/compare/timer_pending out.
module cp0_exception_ctrl_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_pending
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        toggle_q, toggle_d;
  logic        pending_q, pending_d;

  always_comb begin
    toggle_d  = ~toggle_q;
    count_d   = count_q;
    compare_d = compare_q;
    pending_d = pending_q;
    // a software write to Count takes precedence over the increment
    if (count_we)      count_d = wdata;
    else if (toggle_q) count_d = count_q + 32'd1;
    if (compare_we)    compare_d = wdata;
    // clearing on a Compare write wins over a match in the same cycle
    if (compare_we)
      pending_d = 1'b0;
    else if ((count_q == compare_q) && (compare_q != 32'd0))
      pending_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      toggle_q  <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      toggle_q  <= toggle_d;
      pending_q <= pending_d;
    end
  end

  assign count         = count_q;
  assign compare       = compare_q;
  assign timer_pending = pending_q;

endmodule

// File: rtl/cp0_exception_ctrl.sv
// CP0 register file and precise-exception sequencer: commits Status/Cause/
// EPC/BadVAddr on the exception edge, then flushes and redirects for one cycle.
// Ports: exception inputs from MEM, MTC0 write / MFC0 read, int_i, Status/Cause/
// EPC feedback, flush + redirect_valid/redirect_pc, timer_int.
module cp0_exception_ctrl
  import cp0_exception_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] exception_type,
  input  logic [31:0] except_pc,
  input  logic        in_delay_slot,
  input  logic [31:0] bad_addr,
  input  logic        mem_stall,
  input  logic [5:0]  int_i,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_waddr,
  input  logic [31:0] cp0_wdata,
  input  logic [4:0]  cp0_raddr,
  output logic [31:0] cp0_rdata,
  output logic [31:0] cp0_status,
  output logic [31:0] cp0_cause,
  output logic [31:0] cp0_epc,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        timer_int
);

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  state_t      state_q, state_d;
  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic        take;
  logic        is_eret;
  logic        mtc0;
  logic [31:0] count;
  logic [31:0] compare;
  logic        timer_pending;

  // the MEM instruction is being flushed while in S_FLUSH, so its type is ignored
  assign take    = (state_q == S_IDLE) && (exception_type != EXC_NONE) && !mem_stall;
  assign is_eret = (exception_type == EXC_ERET);
  // an exception commit squashes a concurrent MTC0
  assign mtc0    = cp0_we && !take;

  cp0_exception_ctrl_timer u_timer (
    .clk           (clk),
    .rst           (rst),
    .count_we      (mtc0 && (cp0_waddr == CP0_REG_COUNT)),
    .compare_we    (mtc0 && (cp0_waddr == CP0_REG_COMPARE)),
    .wdata         (cp0_wdata),
    .count         (count),
    .compare       (compare),
    .timer_pending (timer_pending)
  );

  always_comb begin
    state_d       = take ? S_FLUSH : S_IDLE;
    status_d      = status_q;
    cause_d       = cause_q;
    epc_d         = epc_q;
    badvaddr_d    = badvaddr_q;
    redirect_pc_d = redirect_pc_q;

    if (take) begin
      if (is_eret) begin
        status_d[CP0_STATUS_EXL] = 1'b0;
        redirect_pc_d            = epc_q;
      end else begin
        status_d[CP0_STATUS_EXL] = 1'b1;
        cause_d[CP0_CAUSE_EXCCODE_MSB:CP0_CAUSE_EXCCODE_LSB] = exc_code(exception_type);
        // nested exception: keep the original return point
        if (!status_q[CP0_STATUS_EXL]) begin
          epc_d                 = in_delay_slot ? (except_pc - 32'd4) : except_pc;
          cause_d[CP0_CAUSE_BD] = in_delay_slot;
        end
        if ((exception_type == EXC_ADEL) || (exception_type == EXC_ADES))
          badvaddr_d = bad_addr;
        redirect_pc_d = EXC_VECTOR;
      end
    end else if (mtc0) begin
      case (cp0_waddr)
        CP0_REG_STATUS: status_d = (status_q & ~CP0_STATUS_WMASK) | (cp0_wdata & CP0_STATUS_WMASK);
        CP0_REG_CAUSE:  cause_d  = (cause_q & ~CP0_CAUSE_WMASK) | (cp0_wdata & CP0_CAUSE_WMASK);
        CP0_REG_EPC:    epc_d    = cp0_wdata;
        default:        ;
      endcase
    end

    // hardware IP bits are resampled every cycle; IP[1:0] are untouched here
    cause_d[CP0_CAUSE_IPS_MSB:CP0_CAUSE_IPS_LSB] = {int_i[5] | timer_pending, int_i[4:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      status_q      <= STATUS_RESET;
      cause_q       <= 32'd0;
      epc_q         <= 32'd0;
      badvaddr_q    <= 32'd0;
      redirect_pc_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      status_q      <= status_d;
      cause_q       <= cause_d;
      epc_q         <= epc_d;
      badvaddr_q    <= badvaddr_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // MFC0 sees the registered values, i.e. read-before-write
  always_comb begin
    case (cp0_raddr)
      CP0_REG_BADVADDR: cp0_rdata = badvaddr_q;
      CP0_REG_COUNT:    cp0_rdata = count;
      CP0_REG_COMPARE:  cp0_rdata = compare;
      CP0_REG_STATUS:   cp0_rdata = status_q;
      CP0_REG_CAUSE:    cp0_rdata = cause_q;
      CP0_REG_EPC:      cp0_rdata = epc_q;
      default:          cp0_rdata = 32'd0;
    endcase
  end

  // reset asserted during FLUSH kills the flush in that same cycle
  assign flush          = (state_q == S_FLUSH) && !rst;
  assign redirect_valid = (state_q == S_FLUSH) && !rst;
  assign redirect_pc    = redirect_pc_q;
  assign cp0_status     = status_q;
  assign cp0_cause      = cause_q;
  assign cp0_epc        = epc_q;
  assign timer_int      = timer_pending;

endmodule

// File: tb/tb_cp0_exception_ctrl.sv
module tb_cp0_exception_ctrl;
  import cp0_exception_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] exception_type;
  logic [31:0] except_pc;
  logic        in_delay_slot;
  logic [31:0] bad_addr;
  logic        mem_stall;
  logic [5:0]  int_i;
  logic        cp0_we;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic [4:0]  cp0_raddr;
  logic [31:0] cp0_rdata;
  logic [31:0] cp0_status;
  logic [31:0] cp0_cause;
  logic [31:0] cp0_epc;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        timer_int;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  cp0_exception_ctrl dut (
    .clk(clk), .rst(rst), .exception_type(exception_type), .except_pc(except_pc),
    .in_delay_slot(in_delay_slot), .bad_addr(bad_addr), .mem_stall(mem_stall),
    .int_i(int_i), .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
    .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata), .cp0_status(cp0_status),
    .cp0_cause(cp0_cause), .cp0_epc(cp0_epc), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .timer_int(timer_int)
  );

  task automatic idle_inputs();
    exception_type = 32'd0; except_pc = 32'd0; in_delay_slot = 1'b0;
    bad_addr = 32'd0; mem_stall = 1'b0; int_i = 6'd0;
    cp0_we = 1'b0; cp0_waddr = 5'd0; cp0_wdata = 32'd0;
  endtask

  task automatic step();
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs(); cp0_raddr = 5'd9;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    total_cnt++; if (cp0_status !== 32'h0040_0000) $display("FAIL reset_status: got %h want %h", cp0_status, 32'h0040_0000); else pass_cnt++;
    total_cnt++; if (cp0_cause !== 32'd0) $display("FAIL reset_cause: got %h want 0", cp0_cause); else pass_cnt++;
    total_cnt++; if (cp0_epc !== 32'd0) $display("FAIL reset_epc: got %h want 0", cp0_epc); else pass_cnt++;
    total_cnt++; if (cp0_rdata !== 32'd0) $display("FAIL reset_count: got %h want 0", cp0_rdata); else pass_cnt++;
    total_cnt++; if (flush !== 1'b0 || redirect_valid !== 1'b0 || timer_int !== 1'b0)
      $display("FAIL reset_ctl: flush=%b rv=%b ti=%b want 000", flush, redirect_valid, timer_int); else pass_cnt++;
  endtask

  task automatic test_delay_slot_ovf();
    exception_type = EXC_OVF; except_pc = 32'hBFC0_1004; in_delay_slot = 1'b1;
    step();
    idle_inputs();
    total_cnt++; if (cp0_epc !== 32'hBFC0_1000) $display("FAIL ovf_epc: got %h want %h", cp0_epc, 32'hBFC0_1000); else pass_cnt++;
    total_cnt++; if (cp0_cause[31] !== 1'b1 || cp0_cause[6:2] !== 5'd12)
      $display("FAIL ovf_cause: bd=%b code=%0d want bd=1 code=12", cp0_cause[31], cp0_cause[6:2]); else pass_cnt++;
    total_cnt++; if (cp0_status[1] !== 1'b1) $display("FAIL ovf_exl: got %b want 1", cp0_status[1]); else pass_cnt++;
    total_cnt++; if (flush !== 1'b1 || redirect_valid !== 1'b1 || redirect_pc !== 32'hBFC0_0380)
      $display("FAIL ovf_redirect: flush=%b rv=%b pc=%h want 1 1 bfc00380", flush, redirect_valid, redirect_pc); else pass_cnt++;
    step();
    total_cnt++; if (flush !== 1'b0 || redirect_valid !== 1'b0)
      $display("FAIL ovf_one_cycle: flush=%b rv=%b want 0 0", flush, redirect_valid); else pass_cnt++;
  endtask

  task automatic test_eret();
    cp0_we = 1'b1; cp0_waddr = CP0_REG_EPC; cp0_wdata = 32'hBFC0_0100;
    step();
    idle_inputs();
    total_cnt++; if (cp0_epc !== 32'hBFC0_0100) $display("FAIL eret_mtc0_epc: got %h want bfc00100", cp0_epc); else pass_cnt++;
    exception_type = EXC_ERET;
    step();
    idle_inputs();
    total_cnt++; if (cp0_status[1] !== 1'b0) $display("FAIL eret_exl: got %b want 0", cp0_status[1]); else pass_cnt++;
    total_cnt++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'hBFC0_0100)
      $display("FAIL eret_redirect: rv=%b pc=%h want 1 bfc00100", redirect_valid, redirect_pc); else pass_cnt++;
    step();
    total_cnt++; if (redirect_valid !== 1'b0) $display("FAIL eret_one_cycle: rv=%b want 0", redirect_valid); else pass_cnt++;
  endtask

  task automatic test_adel_stall();
    cp0_raddr = CP0_REG_BADVADDR;
    exception_type = EXC_ADEL; except_pc = 32'hBFC0_2000; bad_addr = 32'h8000_0003; mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++; if (flush !== 1'b0 || cp0_rdata !== 32'd0)
        $display("FAIL adel_stalled_%0d: flush=%b badv=%h want 0 0", i, flush, cp0_rdata); else pass_cnt++;
    end
    mem_stall = 1'b0;
    step();
    idle_inputs();
    total_cnt++; if (cp0_rdata !== 32'h8000_0003 || cp0_cause[6:2] !== 5'd4 || flush !== 1'b1)
      $display("FAIL adel_release: badv=%h code=%0d flush=%b want 80000003 4 1", cp0_rdata, cp0_cause[6:2], flush); else pass_cnt++;
    step();
  endtask

  task automatic test_collision();
    cp0_we = 1'b1; cp0_waddr = CP0_REG_STATUS; cp0_wdata = 32'd0;  // clear EXL
    step();
    cp0_we = 1'b1; cp0_waddr = CP0_REG_EPC; cp0_wdata = 32'h0000_1234;
    exception_type = EXC_SYSCALL; except_pc = 32'h0000_2000;
    step();
    idle_inputs();
    total_cnt++; if (cp0_epc !== 32'h0000_2000 || cp0_cause[6:2] !== 5'd8)
      $display("FAIL collision: epc=%h code=%0d want 00002000 8", cp0_epc, cp0_cause[6:2]); else pass_cnt++;
    step();
  endtask

  task automatic test_reset_during_flush();
    exception_type = EXC_BREAK; except_pc = 32'h0000_4000;
    step();
    idle_inputs();
    rst = 1'b1; #1;
    total_cnt++; if (flush !== 1'b0 || redirect_valid !== 1'b0)
      $display("FAIL reset_abort_flush: flush=%b rv=%b want 0 0", flush, redirect_valid); else pass_cnt++;
    step();
    rst = 1'b0;
  endtask

  // Reference model of the architectural registers, updated per clock edge
  task automatic test_random();
    logic [31:0] types [8];
    logic [4:0]  codes [8];
    logic [4:0]  waddrs [4];
    logic [31:0] m_status, m_cause, m_epc, m_bad, m_rpc;
    logic        m_flush, taken;
    int          k;
    types = '{EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYSCALL, EXC_BREAK, EXC_RI, EXC_OVF, EXC_ERET};
    codes = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12, 5'd0};
    waddrs = '{5'd8, 5'd12, 5'd13, 5'd14};
    rst = 1'b1; idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    m_status = 32'h0040_0000; m_cause = 32'd0; m_epc = 32'd0; m_bad = 32'd0; m_rpc = 32'd0; m_flush = 1'b0;
    cp0_raddr = CP0_REG_BADVADDR;
    for (int it = 0; it < 60; it++) begin
      k = $urandom_range(0, 7);
      exception_type = ($urandom_range(0, 2) == 0) ? types[k] : 32'd0;
      mem_stall      = ($urandom_range(0, 3) == 0);
      in_delay_slot  = $urandom_range(0, 1);
      except_pc      = $urandom & 32'hFFFF_FFFC;
      bad_addr       = $urandom;
      int_i          = 6'($urandom_range(0, 63));
      cp0_we         = ($urandom_range(0, 2) == 0);
      cp0_waddr      = waddrs[$urandom_range(0, 3)];
      cp0_wdata      = $urandom;
      taken = !m_flush && exception_type != 32'd0 && !mem_stall;
      if (taken) begin
        if (exception_type == EXC_ERET) begin
          m_rpc = m_epc;
          m_status[1] = 1'b0;
        end else begin
          m_rpc = 32'hBFC0_0380;
          m_cause[6:2] = codes[k];
          if (m_status[1] == 1'b0) begin
            m_epc = in_delay_slot ? except_pc - 32'd4 : except_pc;
            m_cause[31] = in_delay_slot;
          end
          if (k == 1 || k == 2) m_bad = bad_addr;
          m_status[1] = 1'b1;
        end
      end else if (cp0_we) begin
        if (cp0_waddr == 5'd12) m_status = {m_status[31:16], cp0_wdata[15:8], m_status[7:2], cp0_wdata[1:0]};
        if (cp0_waddr == 5'd13) m_cause[9:8] = cp0_wdata[9:8];
        if (cp0_waddr == 5'd14) m_epc = cp0_wdata;
      end
      m_cause[15:10] = int_i;
      m_flush = taken;
      step();
      total_cnt++; if (cp0_status !== m_status) $display("FAIL rand_status[%0d]: got %h want %h", it, cp0_status, m_status); else pass_cnt++;
      total_cnt++; if (cp0_cause !== m_cause) $display("FAIL rand_cause[%0d]: got %h want %h", it, cp0_cause, m_cause); else pass_cnt++;
      total_cnt++; if (cp0_epc !== m_epc) $display("FAIL rand_epc[%0d]: got %h want %h", it, cp0_epc, m_epc); else pass_cnt++;
      total_cnt++; if (cp0_rdata !== m_bad) $display("FAIL rand_badvaddr[%0d]: got %h want %h", it, cp0_rdata, m_bad); else pass_cnt++;
      total_cnt++; if (flush !== m_flush || redirect_valid !== m_flush)
        $display("FAIL rand_flush[%0d]: flush=%b rv=%b want %b", it, flush, redirect_valid, m_flush); else pass_cnt++;
      if (m_flush) begin
        total_cnt++; if (redirect_pc !== m_rpc) $display("FAIL rand_rpc[%0d]: got %h want %h", it, redirect_pc, m_rpc); else pass_cnt++;
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_timer();
    int lat = 0;
    idle_inputs();
    cp0_we = 1'b1; cp0_waddr = CP0_REG_COUNT; cp0_wdata = 32'd100;
    step();
    cp0_waddr = CP0_REG_COMPARE; cp0_wdata = 32'd5;
    step();
    cp0_waddr = CP0_REG_COUNT; cp0_wdata = 32'd0;
    step();
    idle_inputs();
    total_cnt++; if (timer_int !== 1'b0) $display("FAIL timer_initial: got %b want 0", timer_int); else pass_cnt++;
    for (int n = 1; n <= 30; n++) begin
      step();
      if (timer_int === 1'b1) begin lat = n; break; end
    end
    total_cnt++; if (lat != 10 && lat != 11) $display("FAIL timer_latency: got %0d cycles (0 = never) want 10 or 11", lat); else pass_cnt++;
    step();
    total_cnt++; if (cp0_cause[15] !== 1'b1 || timer_int !== 1'b1)
      $display("FAIL timer_ip7: ip7=%b ti=%b want 1 1", cp0_cause[15], timer_int); else pass_cnt++;
    cp0_we = 1'b1; cp0_waddr = CP0_REG_COMPARE; cp0_wdata = 32'h0000_1000;
    step();
    idle_inputs();
    total_cnt++; if (timer_int !== 1'b0) $display("FAIL timer_clear: got %b want 0", timer_int); else pass_cnt++;
    step();
    total_cnt++; if (cp0_cause[15] !== 1'b0) $display("FAIL timer_ip7_clear: got %b want 0", cp0_cause[15]); else pass_cnt++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    cp0_raddr = 5'd0;
    test_reset();
    test_delay_slot_ovf();
    test_eret();
    test_adel_stall();
    test_collision();
    test_reset_during_flush();
    test_random();
    test_timer();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
